// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Single-port arbiter and sequencer in front of the word-addressed
//   instruction memory. It shares the memory between the IF-stage fetch port
//   (reads) and the program loader (writes).
//   - BOOT: only the loader is served.
//   - RUN:  fetch has priority, and the loader gets a forced grant after
//           STARVE_MAX consecutive denied cycles.
//   The block also produces the IF stall and the one-cycle-late read valid.
//
// Parameters
//   N          data / instruction width
//   AW         memory word-address width (2**AW words)
//   STARVE_MAX denied loader cycles before a forced loader grant (1..15)
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   fetch_req/fetch_addr     IF read request, byte PC (bits [AW+1:2] used)
//   fetch_gnt                fetch read issued this cycle
//   fetch_rvalid/fetch_rdata read data return, one cycle after fetch_gnt
//   stall_if                 IF must hold its PC
//   ld_req/ld_addr/ld_wdata  loader write request
//   ld_gnt                   loader write issued this cycle
//   boot_done                loader finished, BOOT -> RUN
//   mem_*                    single-port memory interface (synchronous read)
//   running                  FSM is in RUN
//   reboot_req               (only with IMEM_REBOOT_EN) RUN -> BOOT request
//
// Build option
//   IMEM_REBOOT_EN  adds reboot_req. Without it, RUN is left only by reset.
module imem_arbiter #(
  parameter int N          = 32,
  parameter int AW         = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [N-1:0]  fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [N-1:0]  fetch_rdata,
  output logic          stall_if,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_wdata,
  output logic          ld_gnt,
  input  logic          boot_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic          running
`ifdef IMEM_REBOOT_EN
  ,
  input  logic          reboot_req
`endif
);

  localparam logic [0:0] S_BOOT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [3:0]    r_starve;
  logic [3:0]    w_starve_nxt;
  logic          r_rvalid;
  logic          w_force_ld;
  logic [AW-1:0] w_fetch_word;
  logic          w_unused_addr;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  // Only the word-index bits of the byte PC select a memory word. Higher bits
  // alias (wrap) and the byte offset is ignored.
  assign w_fetch_word  = fetch_addr[AW+1:2];
  assign w_unused_addr = ^{fetch_addr[N-1:AW+2], fetch_addr[1:0]};

  assign w_force_ld = (r_state == S_RUN) && ld_req && (r_starve == STARVE_LIM);

  // Grants are gated by rst so that nothing reaches memory while reset is held.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    stall_if  = 1'b1;
    if (rst) begin
      if (r_state == S_BOOT) begin
        ld_gnt = ld_req;
      end else if (w_force_ld) begin
        ld_gnt   = 1'b1;
        stall_if = fetch_req;
      end else begin
        fetch_gnt = fetch_req;
        ld_gnt    = ld_req & ~fetch_req;
        stall_if  = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = (ld_req && !ld_gnt) ? sat_inc(r_starve) : 4'd0;
    if (r_state == S_BOOT) begin
      if (boot_done) w_state_nxt = S_RUN;
    end
`ifdef IMEM_REBOOT_EN
    else if (reboot_req) begin
      w_state_nxt  = S_BOOT;
      w_starve_nxt = 4'd0;
    end
`endif
  end

  // Stage boundary: FSM, starvation counter and read-valid register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_BOOT;
      r_starve <= 4'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_rvalid <= fetch_gnt;
    end
  end

  assign mem_en       = fetch_gnt | ld_gnt;
  assign mem_we       = ld_gnt;
  assign mem_addr     = ld_gnt ? ld_addr : w_fetch_word;
  assign mem_wdata    = ld_wdata;
  assign fetch_rvalid = r_rvalid;
  assign fetch_rdata  = mem_rdata;
  assign running      = (r_state == S_RUN);

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Single-port arbiter and sequencer in front of the word-addressed instruction memory.
- Shares the memory between two requesters:
  - the IF-stage fetch port (reads);
  - a program loader (writes).
- Runs a boot phase (loader only) and then a run phase (fetch priority, with loader anti-starvation).
- Generates the IF stall and the one-cycle-late read-valid for the fetch stage.

Parameters:
- N, 32, instruction/data width in bits
- AW, 3, memory word-address width (2**AW words; default 8)
- STARVE_MAX, 4, consecutive denied loader cycles before the loader is forced a grant in RUN (legal range 1..15)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- fetch_req  input  1  IF stage requests a read this cycle
- fetch_addr  input  N  byte PC; only bits [AW+1:2] are used, other bits ignored
- fetch_gnt  output  1  fetch read issued to memory this cycle
- fetch_rvalid  output  1  fetch_rdata valid (one cycle after fetch_gnt)
- fetch_rdata  output  N  read data, pass-through of mem_rdata
- stall_if  output  1  IF must hold its PC this cycle
- ld_req  input  1  loader requests a write this cycle
- ld_addr  input  AW  loader word address
- ld_wdata  input  N  loader write data
- ld_gnt  output  1  loader write issued this cycle
- boot_done  input  1  loader signals the program is loaded
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory word address
- mem_wdata  output  N  memory write data
- mem_rdata  input  N  memory read data (synchronous read, valid the cycle after mem_en with mem_we=0)
- running  output  1  FSM is in RUN

Behaviour:
Reset:
- While rst=0:
  - state=BOOT, starve_cnt=0, fetch_rvalid=0;
  - all grants, mem_en and mem_we are forced to 0;
  - stall_if=1, running=0.
- Reset is honoured mid-operation; any in-flight read is discarded and no fetch_rvalid follows.

State BOOT:
- fetch_gnt=0, stall_if=1.
- ld_gnt=ld_req.
- BOOT->RUN at a clock edge where boot_done=1.
  - If ld_req=1 in that same cycle, the write is still granted and the transition happens at the same edge.
- boot_done is ignored in RUN.

State RUN:
- Loader forced grant: if ld_req=1 and starve_cnt==STARVE_MAX, then ld_gnt=1, fetch_gnt=0, stall_if=fetch_req.
- Otherwise, fetch has priority:
  - fetch_gnt=fetch_req;
  - ld_gnt=ld_req & ~fetch_req;
  - stall_if=0.
- starve_cnt (width 4):
  - increments when ld_req & ~ld_gnt;
  - clears when ld_gnt or ~ld_req;
  - saturates at STARVE_MAX.
- running=1.

Memory drive (combinational from the grants):
- mem_en = fetch_gnt | ld_gnt.
- mem_we = ld_gnt.
- mem_addr = ld_gnt ? ld_addr : fetch_addr[AW+1:2].
- mem_wdata = ld_wdata.
- At most one grant is ever high.

Read return:
- fetch_rvalid is a register loaded with fetch_gnt.
- Latency is exactly 1 cycle; back-to-back fetches give back-to-back rvalid.

Boundary conditions:
- Address wrap: fetch_addr beyond 2**AW words aliases via the bit slice. Byte offset bits [1:0] are ignored.
- Read after write: a write at cycle t to address A followed by a fetch of A at t+1 returns the new data.
- fetch_req without ld_req in RUN: never stalls.

Optional Feature:
- Macro IMEM_REBOOT_EN.
- Defined:
  - adds input port reboot_req (1 bit, after running);
  - reboot_req=1 in RUN forces state RUN->BOOT at the next edge and clears starve_cnt;
  - a fetch granted in that same cycle still produces fetch_rvalid the next cycle;
  - from the next cycle, BOOT rules apply (stall_if=1, loader only).
- Undefined: no port; RUN is left only by reset.

Test Plan:
- Reset then boot load: rst low 2 cycles, then ld_req with addr 0..7, data 0x11..0x88 in BOOT, fetch_req=1 throughout -> fetch_gnt=0, stall_if=1, 8 writes issued (mem_we=1); boot_done at the last write -> running=1 on the next cycle.
- RUN fetch stream: fetch_addr 0x0,0x4,...,0x1C on consecutive cycles -> fetch_rvalid=1 one cycle after each grant, with rdata 0x11..0x88 in order; stall_if=0.
- Starvation: fetch_req held 1 and ld_req=1 (addr 3, data 0xDEAD) -> ld_gnt exactly on the 5th ld_req cycle (STARVE_MAX=4); stall_if=1 and fetch_gnt=0 only in that cycle; a following fetch of 0xC returns 0xDEAD.
- Idle-fetch write: fetch_req=0, ld_req=1 in RUN -> ld_gnt the same cycle, starve_cnt remains 0.
- Wrap/alignment: fetch_addr 0x23 -> mem_addr=0, rdata equals word 0.
- Async reset mid-read: rst low between fetch_gnt and the next edge -> fetch_rvalid stays 0, state=BOOT. With IMEM_REBOOT_EN: reboot_req in RUN -> BOOT next cycle, in-flight rvalid still seen.
